// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and tick constants
//   ST_*      : receiver/transmitter FSM states
//   MID_TICK  : tick index at the middle of the start bit
//   LAST_TICK : tick index at the middle of a data/parity bit
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [4:0] MID_TICK  = 5'd7;
  localparam logic [4:0] LAST_TICK = 5'd15;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver output bundle towards the downstream FIFO stage
//   o_rx_done    : one-cycle frame-complete strobe
//   o_data       : last received word
//   o_frame_err  : stop bit sampled low, pulsed with o_rx_done
//   o_parity_err : even-parity error (only with UART_RX_PARITY_EN)
//   master modport: driven by uart_rx; slave modport: consumer side
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 o_rx_done;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 o_parity_err;

  modport master (output o_rx_done, output o_data, output o_frame_err, output o_parity_err);
  modport slave  (input  o_rx_done, input  o_data, input  o_frame_err, input  o_parity_err);
`else
  modport master (output o_rx_done, output o_data, output o_frame_err);
  modport slave  (input  o_rx_done, input  o_data, input  o_frame_err);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchroniser for the asynchronous rx line
//   i_clk, i_reset (async active-low), i_d (async in), o_q (synchronised out)
//   Resets to 1 so an idle-high line never looks like a start edge.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, LSB first
//   i_clk, i_reset (async active-low), i_s_tick (oversampling tick), i_rx (serial line)
//   rx_if (master): o_rx_done, o_data, o_frame_err [, o_parity_err]
//   Optional even parity enabled by macro UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SB_TICK     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_s_tick,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);

  localparam int NW = $clog2(DATA_BITS);

  logic                 w_rx_s;
  logic                 r_rx_q;
  state_t               r_state,  w_state_n;
  logic [4:0]           r_s_cnt,  w_s_cnt_n;
  logic [NW-1:0]        r_n_cnt,  w_n_cnt_n;
  logic [DATA_BITS-1:0] r_b_reg,  w_b_reg_n;
  logic [DATA_BITS-1:0] r_data,   w_data_n;
  logic                 r_done,   w_done_n;
  logic                 r_ferr,   w_ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 r_par,    w_par_n;
  logic                 r_perr,   w_perr_n;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_q  <= 1'b1;
      r_state <= ST_IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_b_reg <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_rx_q  <= w_rx_s;
      r_state <= w_state_n;
      r_s_cnt <= w_s_cnt_n;
      r_n_cnt <= w_n_cnt_n;
      r_b_reg <= w_b_reg_n;
      r_data  <= w_data_n;
      r_done  <= w_done_n;
      r_ferr  <= w_ferr_n;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_n;
      r_perr  <= w_perr_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_s_cnt_n = r_s_cnt;
    w_n_cnt_n = r_n_cnt;
    w_b_reg_n = r_b_reg;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
    w_ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_n   = r_par;
    w_perr_n  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Edge-triggered so a held-low (break) line never starts a frame.
        if (r_rx_q && !w_rx_s) begin
          w_state_n = ST_START;
          w_s_cnt_n = '0;
        end
      end
      ST_START: begin
        if (i_s_tick) begin
          if (r_s_cnt == MID_TICK) begin
            // Line back high at mid start bit: treat as a glitch.
            w_state_n = w_rx_s ? ST_IDLE : ST_DATA;
            w_s_cnt_n = '0;
            w_n_cnt_n = '0;
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (i_s_tick) begin
          if (r_s_cnt == LAST_TICK) begin
            w_b_reg_n = {w_rx_s, r_b_reg[DATA_BITS-1:1]};
            w_s_cnt_n = '0;
            if (r_n_cnt == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_n = ST_PARITY;
`else
              w_state_n = ST_STOP;
`endif
            end else begin
              w_n_cnt_n = r_n_cnt + 1'b1;
            end
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_s_tick) begin
          if (r_s_cnt == LAST_TICK) begin
            w_par_n   = w_rx_s;
            w_s_cnt_n = '0;
            w_state_n = ST_STOP;
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_s_tick) begin
          if (r_s_cnt == 5'(SB_TICK - 1)) begin
            // Word is delivered even when the stop bit is bad.
            w_state_n = ST_IDLE;
            w_s_cnt_n = '0;
            w_done_n  = 1'b1;
            w_data_n  = r_b_reg;
            w_ferr_n  = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
            w_perr_n  = ^{r_b_reg, r_par};
`endif
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign rx_if.o_rx_done    = r_done;
  assign rx_if.o_data       = r_data;
  assign rx_if.o_frame_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (optional UART_RX_PARITY_EN)
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic s_tick;
  logic tb_par = 1'b0;
  int   tick_cnt = 0;

  int n_checks = 0;
  int n_pass = 0;
  int n_pulse = 0;
  int base;
  logic [7:0] q_data[$];
  logic       q_ferr[$];
  logic       q_perr[$];

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx #(.DATA_BITS(8), .SB_TICK(16), .SYNC_STAGES(2)) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .i_s_tick (s_tick),
    .i_rx     (rx),
    .rx_if    (rx_if.master)
  );

  always #5 clk = ~clk;

  // Baud generator model, divisor 4: one-clock tick every 4 clocks.
  always @(posedge clk) tick_cnt <= (tick_cnt == 3) ? 0 : tick_cnt + 1;
  assign s_tick = (tick_cnt == 3);

  always @(negedge clk) begin
    if (rx_if.o_rx_done) begin
      n_pulse++;
      q_data.push_back(rx_if.o_data);
      q_ferr.push_back(rx_if.o_frame_err);
`ifdef UART_RX_PARITY_EN
      q_perr.push_back(rx_if.o_parity_err);
`else
      q_perr.push_back(1'b0);
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(tb_par);
`endif
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_d, input logic exp_f);
    logic [7:0] d;
    logic f;
    if (q_data.size() > 0) begin
      d = q_data.pop_front();
      f = q_ferr.pop_front();
      void'(q_perr.pop_front());
    end else begin
      d = 8'hxx;
      f = 1'bx;
    end
    check({tag, "_data"}, 32'(d), 32'(exp_d));
    check({tag, "_ferr"}, 32'(f), 32'(exp_f));
  endtask

  initial begin
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_done", 32'(rx_if.o_rx_done), 32'd0);
    check("rst_data", 32'(rx_if.o_data), 32'd0);
    check("rst_ferr", 32'(rx_if.o_frame_err), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // T1: clean 0x55
    base = n_pulse;
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_pulses", 32'(n_pulse - base), 32'd1);
    pop_check("t1", 8'h55, 1'b0);

    // T2: 3-tick glitch rejected
    base = n_pulse;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    check("t2_pulses", 32'(n_pulse - base), 32'd0);
    check("t2_state", 32'(dut.r_state), 32'(ST_IDLE));

    // T3: 0xA3 with low stop bit
    base = n_pulse;
    send_frame(8'hA3, 1'b0);
    repeat (40) @(negedge clk);
    check("t3_pulses", 32'(n_pulse - base), 32'd1);
    pop_check("t3", 8'hA3, 1'b1);

    // T4: reset during 4th data bit of 0x3C, then 0x0F
    base = n_pulse;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_done", 32'(rx_if.o_rx_done), 32'd0);
    check("t4_rst_data", 32'(rx_if.o_data), 32'd0);
    check("t4_rst_ferr", 32'(rx_if.o_frame_err), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t4_abort_pulses", 32'(n_pulse - base), 32'd0);
    check("t4_state", 32'(dut.r_state), 32'(ST_IDLE));
    send_frame(8'h0F, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_pulses", 32'(n_pulse - base), 32'd1);
    pop_check("t4", 8'h0F, 1'b0);

    // T5: back-to-back 0x00 then 0xFF
    base = n_pulse;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("t5_pulses", 32'(n_pulse - base), 32'd2);
    pop_check("t5a", 8'h00, 1'b0);
    pop_check("t5b", 8'hFF, 1'b0);

`ifdef UART_RX_PARITY_EN
    // T6: even parity on 0x07 (three ones)
    base = n_pulse;
    tb_par = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("t6a_perr", 32'((q_perr.size() > 0) ? q_perr[0] : 1'bx), 32'd1);
    pop_check("t6a", 8'h07, 1'b0);
    tb_par = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("t6b_perr", 32'((q_perr.size() > 0) ? q_perr[0] : 1'bx), 32'd0);
    pop_check("t6b", 8'h07, 1'b0);
    check("t6_pulses", 32'(n_pulse - base), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
